// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the pulse train generator.
// Holds the FSM state encoding and the default counter width.
package pulse_gen_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_gen_counter.sv
// Loadable down counter for period and remaining-pulse tracking.
// Load wins over enable; the counter holds at zero and never wraps.
module pulse_gen_counter
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    // A value of one marks the last cycle of the current period.
    assign expired = (value == '0) || (value == CNT_W'(1));

endmodule

// File: rtl/pulse_train_generator.sv
// Pulse train generator: FSM plus registered out/done/ready.
// Define PULSE_GEN_RETRIGGER_EN to let start restart a running train.
module pulse_train_generator
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    input  logic [CNT_W-1:0] count,
    output logic             ready,
    output logic             out,
    output logic             done
);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] gap_q;
    logic             accept;
    logic             per_load;
    logic             per_en;
    logic [CNT_W-1:0] per_val;
    logic             per_exp;
    logic             rem_load;
    logic             rem_en;
    logic             rem_exp;

    function automatic logic [CNT_W-1:0] at_least_one(
        input logic [CNT_W-1:0] v
    );
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

`ifdef PULSE_GEN_RETRIGGER_EN
    assign accept = start && (state != DONE);
`else
    assign accept = start && (state == IDLE);
`endif

    pulse_gen_counter #(.CNT_W(CNT_W)) u_period (
        .clk      (clk),
        .rst      (rst),
        .load     (per_load),
        .en       (per_en),
        .load_val (per_val),
        .expired  (per_exp)
    );

    pulse_gen_counter #(.CNT_W(CNT_W)) u_remain (
        .clk      (clk),
        .rst      (rst),
        .load     (rem_load),
        .en       (rem_en),
        .load_val (count),
        .expired  (rem_exp)
    );

    always_comb begin
        state_nx = state;
        per_load = 1'b0;
        per_en   = 1'b0;
        per_val  = width_q;
        rem_load = 1'b0;
        rem_en   = 1'b0;

        unique case (state)
            IDLE: begin
            end
            HIGH: begin
                per_en = 1'b1;
                if (per_exp) begin
                    rem_en = 1'b1;
                    if (rem_exp) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = LOW;
                        per_load = 1'b1;
                        per_val  = gap_q;
                    end
                end
            end
            LOW: begin
                per_en = 1'b1;
                if (per_exp) begin
                    state_nx = HIGH;
                    per_load = 1'b1;
                    per_val  = width_q;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
        endcase

        // Acceptance overrides whatever the running train wanted.
        if (accept) begin
            if (count != '0) begin
                state_nx = HIGH;
                per_load = 1'b1;
                per_val  = at_least_one(width);
                rem_load = 1'b1;
            end else begin
                state_nx = DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            out     <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
            width_q <= '0;
            gap_q   <= '0;
        end else begin
            state <= state_nx;
            out   <= (state_nx == HIGH);
            done  <= (state_nx == DONE);
            ready <= (state_nx == IDLE);
            if (accept) begin
                width_q <= at_least_one(width);
                gap_q   <= at_least_one(gap);
            end
        end
    end

    a_done_single: assert property (
        @(posedge clk) disable iff (rst) done |=> !done
    );

    a_idle_quiet: assert property (
        @(posedge clk) disable iff (rst) ready |-> (!out && !done)
    );

    a_out_state: assert property (
        @(posedge clk) disable iff (rst) out == (state == HIGH)
    );

endmodule

// File: tb/tb_pulse_train_generator.sv
// Scoreboard bench: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_pulse_train_generator;

    typedef struct {
        int    cyc;
        logic  o;
        logic  d;
        logic  r;
        string tag;
    } exp_t;

    localparam int BIG = 1 << 30;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] width = '0;
    logic [7:0] gap   = '0;
    logic [7:0] count = '0;
    logic       ready;
    logic       out;
    logic       done;

    int   cyc       = 0;
    int   checks    = 0;
    int   passed    = 0;
    int   edges     = 0;
    int   exp_edges = 0;
    logic out_d     = 1'b0;
    exp_t sb[$];
    exp_t e;

    pulse_train_generator #(.CNT_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .width (width),
        .gap   (gap),
        .count (count),
        .ready (ready),
        .out   (out),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out === 1'b1 && out_d === 1'b0) edges++;
        out_d = out;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc == cyc && out === e.o &&
                done === e.d && ready === e.r) begin
                passed++;
            end else begin
                $display("FAIL %s cyc=%0d/%0d: out=%b done=%b ready=%b, want out=%b done=%b ready=%b",
                         e.tag, cyc, e.cyc, out, done, ready,
                         e.o, e.d, e.r);
            end
        end
    end

    function automatic int sat(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic push(input int c, input logic o, input logic d,
                        input logic r, input string tag);
        exp_t x;
        x.cyc = c;
        x.o   = o;
        x.d   = d;
        x.r   = r;
        x.tag = tag;
        sb.push_back(x);
    endtask

    // dc is the hand-computed done offset from the start cycle.
    task automatic push_train(input int b, input int w, input int g,
                              input int n, input int dc,
                              input int limit, input string tag);
        int p;
        p = sat(w) + sat(g);
        for (int o = 1; o <= dc + 1 && o <= limit; o++) begin
            push(b + o,
                 (n != 0) && (o < dc) && (((o - 1) % p) < sat(w)),
                 o == dc, o == dc + 1, tag);
        end
    endtask

    // Entered at posedge+1 of an idle cycle; leaves at the ready cycle.
    task automatic run(input int w, input int g, input int n,
                       input int dc, input int ed, input string tag);
        int b;
        start = 1'b1;
        width = 8'(w);
        gap   = 8'(g);
        count = 8'(n);
        b     = cyc;
        push_train(b, w, g, n, dc, BIG, tag);
        exp_edges += ed;
        @(posedge clk); #1;
        start = 1'b0;
        width = 8'hA5;
        gap   = 8'h5A;
        count = 8'h77;
        repeat (dc) @(posedge clk);
        #1;
    endtask

    initial begin
        int b;
        int r;
        repeat (2) @(posedge clk);
        #1;
        push(cyc, 1'b0, 1'b0, 1'b1, "reset");
        @(posedge clk); #1;
        rst = 1'b0;
        push(cyc, 1'b0, 1'b0, 1'b1, "post_reset");
        @(posedge clk); #1;

        run(1, 1, 3, 6, 3, "w1g1c3");
        run(3, 2, 2, 9, 2, "w3g2c2");
        run(5, 0, 0, 1, 0, "count0");
        run(0, 0, 2, 4, 2, "w0g0c2");
        run(2, 3, 1, 3, 1, "w2g3c1");

        // Reset lands in the second high period of a 4/4/3 train.
        start = 1'b1;
        width = 8'd4;
        gap   = 8'd4;
        count = 8'd3;
        b     = cyc;
        push_train(b, 4, 4, 3, 21, 9, "abort");
        exp_edges += 2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 10; k <= 13; k++)
            push(b + k, 1'b0, 1'b0, 1'b1, "abort_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run(4, 4, 3, 21, 3, "after_rst");

        // Second start two cycles into a 3/2/3 train.
        start = 1'b1;
        width = 8'd3;
        gap   = 8'd2;
        count = 8'd3;
        b     = cyc;
`ifdef PULSE_GEN_RETRIGGER_EN
        push_train(b, 3, 2, 3, 14, 2, "rt_old");
        push_train(b + 2, 2, 1, 2, 6, BIG, "rt_new");
        exp_edges += 2;
        r = 9;
`else
        push_train(b, 3, 2, 3, 14, BIG, "rt_ignored");
        exp_edges += 3;
        r = 15;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        width = 8'd2;
        gap   = 8'd1;
        count = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        width = 8'hA5;
        gap   = 8'h5A;
        count = 8'h77;
        repeat (r - 3) @(posedge clk);
        #1;
        run(1, 1, 1, 2, 1, "btb");

        for (int k = 0; k < 20 && sb.size() > 0; k++)
            @(posedge clk);
        @(posedge clk); #1;

        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL sb_drain: left=%0d want=0", sb.size());
        checks++;
        if (edges == exp_edges) passed++;
        else $display("FAIL edge_count: got=%0d want=%0d",
                      edges, exp_edges);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
